// File: rtl/mem_channel_controller_pkg.sv
// Shared definitions for the memory channel controller.
//   - Global data / instruction widths and their word/address typedefs.
//   - channel_state_t: 3-bit per-channel FSM state.
package mem_channel_controller_pkg;

   localparam int unsigned DATA_WIDTH                       = 16;
   localparam int unsigned INSTRUCTION_WIDTH                = 16;
   localparam int unsigned DATA_MEMORY_ADDRESS_WIDTH        = 8;
   localparam int unsigned INSTRUCTION_MEMORY_ADDRESS_WIDTH = 8;

   typedef logic [DATA_WIDTH-1:0]                       data_t;
   typedef logic [DATA_MEMORY_ADDRESS_WIDTH-1:0]        data_memory_address_t;
   typedef logic [INSTRUCTION_WIDTH-1:0]                instruction_t;
   typedef logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] instruction_memory_address_t;

   typedef enum logic [2:0] {
      CH_IDLE           = 3'd0,
      CH_READ_WAITING   = 3'd1,
      CH_WRITE_WAITING  = 3'd2,
      CH_READ_RELAYING  = 3'd3,
      CH_WRITE_RELAYING = 3'd4
   } channel_state_t;

endpackage

// File: rtl/mem_channel_controller.sv
// Multi-channel memory request arbiter.
// NUM_CONSUMERS requesters share NUM_CHANNELS memory ports. Each idle channel
// claims the lowest-index unclaimed consumer with a pending request (read has
// priority over write), forwards it to memory, waits for completion and holds
// the result towards the consumer until it drops its valid.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   consumer_read_*            per-consumer read request / completion + data
//   consumer_write_*           per-consumer write request / completion
//   mem_read_*                 per-channel memory read port
//   mem_write_*                per-channel memory write port (0 when WRITE_ENABLE=0)
// All outputs are registered.
module mem_channel_controller #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned NUM_CONSUMERS = 4,
   parameter int unsigned NUM_CHANNELS  = 1,
   parameter bit          WRITE_ENABLE  = 1'b1
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [NUM_CONSUMERS-1:0]                     consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDRESS_WIDTH-1:0]  consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                     consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]     consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                     consumer_write_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDRESS_WIDTH-1:0]  consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]     consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                     consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]                      mem_read_valid,
   output logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]   mem_read_address,
   input  logic [NUM_CHANNELS-1:0]                      mem_read_ready,
   input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]      mem_read_data,
   output logic [NUM_CHANNELS-1:0]                      mem_write_valid,
   output logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]   mem_write_address,
   output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]      mem_write_data,
   input  logic [NUM_CHANNELS-1:0]                      mem_write_ready
);

   import mem_channel_controller_pkg::*;

   localparam int unsigned IDXW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   typedef logic [IDXW-1:0] idx_t;

   channel_state_t state [NUM_CHANNELS];
   idx_t           owner [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] claimed;

   logic [NUM_CHANNELS-1:0] grant;
   logic [NUM_CHANNELS-1:0] grant_read;
   idx_t                    grant_idx [NUM_CHANNELS];

   logic [NUM_CHANNELS-1:0]                    wr_valid_q;
   logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] wr_address_q;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    wr_data_q;
   logic [NUM_CONSUMERS-1:0]                   wr_ready_q;

   // Channels scan in index order; 'taken' accumulates this cycle's claims so
   // a higher channel never picks a consumer a lower channel just claimed.
   always_comb begin : scan
      logic [NUM_CONSUMERS-1:0] taken;
      taken      = claimed;
      grant      = '0;
      grant_read = '0;
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
         grant_idx[ch] = '0;
         if (state[ch] == CH_IDLE) begin
            for (int unsigned c = 0; c < NUM_CONSUMERS; c++) begin
               if (!grant[ch] && !taken[c] &&
                   (consumer_read_valid[c] || (WRITE_ENABLE && consumer_write_valid[c]))) begin
                  grant[ch]      = 1'b1;
                  grant_idx[ch]  = idx_t'(c);
                  grant_read[ch] = consumer_read_valid[c];
                  taken[c]       = 1'b1;
               end
            end
         end
      end
   end

   // Memory valid is raised one cycle after the claim: the claim edge only
   // latches the request, the waiting state then presents it to memory and
   // ignores the ready input until its own valid is visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            state[ch] <= CH_IDLE;
            owner[ch] <= '0;
         end
         claimed             <= '0;
         consumer_read_ready <= '0;
         consumer_read_data  <= '0;
         mem_read_valid      <= '0;
         mem_read_address    <= '0;
         wr_valid_q          <= '0;
         wr_address_q        <= '0;
         wr_data_q           <= '0;
         wr_ready_q          <= '0;
      end else begin
         for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state[ch])
               CH_IDLE: begin
                  if (grant[ch]) begin
                     claimed[grant_idx[ch]] <= 1'b1;
                     owner[ch]              <= grant_idx[ch];
                     if (grant_read[ch]) begin
                        mem_read_address[ch] <= consumer_read_address[grant_idx[ch]];
                        state[ch]            <= CH_READ_WAITING;
                     end else begin
                        wr_address_q[ch] <= consumer_write_address[grant_idx[ch]];
                        wr_data_q[ch]    <= consumer_write_data[grant_idx[ch]];
                        state[ch]        <= CH_WRITE_WAITING;
                     end
                  end
               end
               CH_READ_WAITING: begin
                  if (!mem_read_valid[ch]) begin
                     mem_read_valid[ch] <= 1'b1;
                  end else if (mem_read_ready[ch]) begin
                     consumer_read_data[owner[ch]]  <= mem_read_data[ch];
                     consumer_read_ready[owner[ch]] <= 1'b1;
                     mem_read_valid[ch]             <= 1'b0;
                     state[ch]                      <= CH_READ_RELAYING;
                  end
               end
               CH_WRITE_WAITING: begin
                  if (!wr_valid_q[ch]) begin
                     wr_valid_q[ch] <= 1'b1;
                  end else if (mem_write_ready[ch]) begin
                     wr_ready_q[owner[ch]] <= 1'b1;
                     wr_valid_q[ch]        <= 1'b0;
                     state[ch]             <= CH_WRITE_RELAYING;
                  end
               end
               CH_READ_RELAYING: begin
                  if (!consumer_read_valid[owner[ch]]) begin
                     consumer_read_ready[owner[ch]] <= 1'b0;
                     claimed[owner[ch]]             <= 1'b0;
                     state[ch]                      <= CH_IDLE;
                  end
               end
               CH_WRITE_RELAYING: begin
                  if (!consumer_write_valid[owner[ch]]) begin
                     wr_ready_q[owner[ch]] <= 1'b0;
                     claimed[owner[ch]]    <= 1'b0;
                     state[ch]             <= CH_IDLE;
                  end
               end
               default: state[ch] <= CH_IDLE;
            endcase
         end
      end
   end

   generate
      if (WRITE_ENABLE) begin : g_write
         assign mem_write_valid      = wr_valid_q;
         assign mem_write_address    = wr_address_q;
         assign mem_write_data       = wr_data_q;
         assign consumer_write_ready = wr_ready_q;
      end else begin : g_no_write
         assign mem_write_valid      = '0;
         assign mem_write_address    = '0;
         assign mem_write_data       = '0;
         assign consumer_write_ready = '0;
      end
   endgenerate

endmodule

// File: tb/tb_mem_channel_controller.sv
// Self-checking bench for mem_channel_controller.
// Instance m: default configuration (1 channel, read/write).
// Instance p: 2 channels, read-only.
// Bench-side memory responders answer requests after a programmable delay;
// expected completions are queued when stimulus is driven and compared when
// the DUT raises a consumer ready.
module tb_mem_channel_controller;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int NC = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // instance m
   logic [NC-1:0]         m_crv, m_crr, m_cwv, m_cwr;
   logic [NC-1:0][AW-1:0] m_cra, m_cwa;
   logic [NC-1:0][DW-1:0] m_crd, m_cwd;
   logic [0:0]            m_mrv, m_mrr, m_mwv, m_mwr;
   logic [0:0][AW-1:0]    m_mra, m_mwa;
   logic [0:0][DW-1:0]    m_mrd, m_mwd;

   // instance p
   logic [NC-1:0]         p_crv, p_crr, p_cwv, p_cwr;
   logic [NC-1:0][AW-1:0] p_cra, p_cwa;
   logic [NC-1:0][DW-1:0] p_crd, p_cwd;
   logic [1:0]            p_mrv, p_mrr, p_mwv, p_mwr;
   logic [1:0][AW-1:0]    p_mra, p_mwa;
   logic [1:0][DW-1:0]    p_mrd, p_mwd;

   mem_channel_controller dut_m (
      .clk(clk), .reset(reset),
      .consumer_read_valid(m_crv), .consumer_read_address(m_cra),
      .consumer_read_ready(m_crr), .consumer_read_data(m_crd),
      .consumer_write_valid(m_cwv), .consumer_write_address(m_cwa),
      .consumer_write_data(m_cwd), .consumer_write_ready(m_cwr),
      .mem_read_valid(m_mrv), .mem_read_address(m_mra),
      .mem_read_ready(m_mrr), .mem_read_data(m_mrd),
      .mem_write_valid(m_mwv), .mem_write_address(m_mwa),
      .mem_write_data(m_mwd), .mem_write_ready(m_mwr)
   );

   mem_channel_controller #(.NUM_CHANNELS(2), .WRITE_ENABLE(1'b0)) dut_p (
      .clk(clk), .reset(reset),
      .consumer_read_valid(p_crv), .consumer_read_address(p_cra),
      .consumer_read_ready(p_crr), .consumer_read_data(p_crd),
      .consumer_write_valid(p_cwv), .consumer_write_address(p_cwa),
      .consumer_write_data(p_cwd), .consumer_write_ready(p_cwr),
      .mem_read_valid(p_mrv), .mem_read_address(p_mra),
      .mem_read_ready(p_mrr), .mem_read_data(p_mrd),
      .mem_write_valid(p_mwv), .mem_write_address(p_mwa),
      .mem_write_data(p_mwd), .mem_write_ready(p_mwr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int          cons;
      logic [15:0] data;
   } exp_t;

   exp_t m_rq[$];
   exp_t m_wq[$];
   exp_t p_rq[$];

   logic [15:0] mem [256];
   int rd_lat = 0;
   int wr_lat = 0;

   function automatic exp_t mk(input int c, input logic [15:0] d);
      exp_t e;
      e.cons = c;
      e.data = d;
      return e;
   endfunction

   // memory responder for instance m
   initial begin : m_mem
      bit rbusy, wbusy;
      int rcnt, wcnt;
      logic [7:0] raddr, waddr;
      logic [15:0] wdata;
      rbusy = 0; wbusy = 0; rcnt = 0; wcnt = 0; raddr = '0; waddr = '0; wdata = '0;
      m_mrr = '0; m_mrd = '0; m_mwr = '0;
      forever begin
         @(posedge clk); #1;
         if (m_mrr[0]) begin
            m_mrr[0] = 1'b0;
            rbusy = 0;
         end else if (m_mrv[0]) begin
            if (!rbusy) begin
               rbusy = 1; rcnt = rd_lat; raddr = m_mra[0];
            end else check("m_rd_addr_held", m_mra[0], raddr);
            if (rcnt == 0) begin
               m_mrd[0] = mem[m_mra[0]];
               m_mrr[0] = 1'b1;
            end else rcnt--;
         end else rbusy = 0;

         if (m_mwr[0]) begin
            m_mwr[0] = 1'b0;
            wbusy = 0;
         end else if (m_mwv[0]) begin
            if (!wbusy) begin
               wbusy = 1; wcnt = wr_lat; waddr = m_mwa[0]; wdata = m_mwd[0];
            end else begin
               check("m_wr_addr_held", m_mwa[0], waddr);
               check("m_wr_data_held", m_mwd[0], wdata);
            end
            if (wcnt == 0) begin
               mem[m_mwa[0]] = m_mwd[0];
               m_mwr[0] = 1'b1;
            end else wcnt--;
         end else wbusy = 0;
      end
   end

   // memory responder for instance p: both channels answer after one extra cycle
   initial begin : p_mem
      bit pbusy [2];
      int pcnt [2];
      for (int i = 0; i < 2; i++) begin pbusy[i] = 0; pcnt[i] = 0; end
      p_mrr = '0; p_mrd = '0; p_mwr = '0;
      forever begin
         @(posedge clk); #1;
         for (int ch = 0; ch < 2; ch++) begin
            if (p_mrr[ch]) begin
               p_mrr[ch] = 1'b0;
               pbusy[ch] = 0;
            end else if (p_mrv[ch]) begin
               if (!pbusy[ch]) begin pbusy[ch] = 1; pcnt[ch] = 1; end
               if (pcnt[ch] == 0) begin
                  p_mrd[ch] = mem[p_mra[ch]];
                  p_mrr[ch] = 1'b1;
               end else pcnt[ch]--;
            end else pbusy[ch] = 0;
         end
      end
   end

   // scoreboard monitors: compare on each rising consumer ready
   initial begin : m_mon
      logic [NC-1:0] prev_r, prev_w;
      exp_t e;
      prev_r = '0; prev_w = '0;
      forever begin
         @(posedge clk); #1;
         for (int c = 0; c < NC; c++) begin
            if (m_crr[c] && !prev_r[c]) begin
               check("m_rd_expected", m_rq.size() > 0, 1);
               if (m_rq.size() > 0) begin
                  e = m_rq.pop_front();
                  check("m_rd_order", c, e.cons);
                  check("m_rd_data", m_crd[c], e.data);
               end
            end
            if (m_cwr[c] && !prev_w[c]) begin
               check("m_wr_expected", m_wq.size() > 0, 1);
               if (m_wq.size() > 0) begin
                  e = m_wq.pop_front();
                  check("m_wr_order", c, e.cons);
               end
            end
         end
         prev_r = m_crr;
         prev_w = m_cwr;
      end
   end

   initial begin : p_mon
      logic [NC-1:0] prev_r;
      bit found;
      prev_r = '0;
      forever begin
         @(posedge clk); #1;
         for (int c = 0; c < NC; c++) begin
            if (p_crr[c] && !prev_r[c]) begin
               found = 0;
               for (int k = 0; k < p_rq.size(); k++) begin
                  if (!found && p_rq[k].cons == c) begin
                     check("p_rd_data", p_crd[c], p_rq[k].data);
                     p_rq.delete(k);
                     found = 1;
                  end
               end
               check("p_rd_match", found, 1);
            end
         end
         prev_r = p_crr;
      end
   end

   // consumer drivers for instance m: lat counts edges from request to ready
   task automatic m_read(input int c, input logic [7:0] a, input int hold, output int lat);
      m_cra[c] = a;
      m_crv[c] = 1'b1;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!m_crr[c] && lat < 60);
      if (!m_crr[c]) check("m_rd_timeout", m_crr[c], 1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("m_rd_ready_held", m_crr[c], 1);
      end
      m_crv[c] = 1'b0;
      @(posedge clk); #1;
      check("m_rd_ready_cleared", m_crr[c], 0);
   endtask

   task automatic m_write(input int c, input logic [7:0] a, input logic [15:0] d, output int lat);
      m_cwa[c] = a;
      m_cwd[c] = d;
      m_cwv[c] = 1'b1;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!m_cwr[c] && lat < 60);
      if (!m_cwr[c]) check("m_wr_timeout", m_cwr[c], 1);
      m_cwv[c] = 1'b0;
      @(posedge clk); #1;
      check("m_wr_ready_cleared", m_cwr[c], 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin : main
      int lat, lat0, lat1, lat2, cnt;
      for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h3C, 8'(i)};
      mem[8'h2A] = 16'h1234;
      m_crv = '0; m_cra = '0; m_cwv = '0; m_cwa = '0; m_cwd = '0;
      p_crv = '0; p_cra = '0; p_cwv = '0; p_cwa = '0; p_cwd = '0;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("m_reset_outputs", |{m_crr, m_crd, m_cwr, m_mrv, m_mra, m_mwv, m_mwa, m_mwd}, 0);
      check("p_reset_outputs", |{p_crr, p_crd, p_cwr, p_mrv, p_mra, p_mwv, p_mwa, p_mwd}, 0);
      reset = 1'b0;

      // single read, memory answers two cycles after the request appears
      rd_lat = 2;
      m_rq.push_back(mk(1, 16'h1234));
      fork
         m_read(1, 8'h2A, 1, lat);
         begin
            @(posedge clk); #1;
            check("rd_valid_not_early", m_mrv[0], 0);
            @(posedge clk); #1;
            check("rd_valid", m_mrv[0], 1);
            check("rd_addr", m_mra[0], 8'h2A);
         end
      join
      check("rd_latency", lat, 5);
      check("rd_data_kept", m_crd[1], 16'h1234);

      // single write
      wr_lat = 2;
      m_wq.push_back(mk(0, 16'h0));
      fork
         m_write(0, 8'h10, 16'h00BE, lat);
         begin
            repeat (2) begin @(posedge clk); #1; end
            check("wr_valid", m_mwv[0], 1);
            check("wr_addr", m_mwa[0], 8'h10);
            check("wr_data", m_mwd[0], 16'h00BE);
         end
      join
      check("wr_mem_content", mem[8'h10], 16'h00BE);

      // read-back with immediate memory response: minimum latency
      rd_lat = 0;
      m_rq.push_back(mk(3, 16'h00BE));
      m_read(3, 8'h10, 0, lat);
      check("rd_min_latency", lat, 3);

      // contention on one channel: served 0, 1, 2 each after the previous release
      rd_lat = 1;
      m_rq.push_back(mk(0, mem[8'h40]));
      m_rq.push_back(mk(1, mem[8'h41]));
      m_rq.push_back(mk(2, mem[8'h42]));
      fork
         m_read(0, 8'h40, 0, lat0);
         m_read(1, 8'h41, 0, lat1);
         m_read(2, 8'h42, 0, lat2);
      join
      check("cont_lat0", lat0, 4);
      check("cont_lat1", lat1, 9);
      check("cont_lat2", lat2, 14);

      // reset while the channel waits on memory; the request is re-served
      rd_lat = 6;
      m_rq.push_back(mk(2, mem[8'h55]));
      fork
         m_read(2, 8'h55, 0, lat);
         begin
            repeat (3) begin @(posedge clk); #1; end
            check("mid_read_valid", m_mrv[0], 1);
            reset = 1'b1;
            @(posedge clk); #1;
            check("mid_reset_outputs", |{m_crr, m_crd, m_cwr, m_mrv, m_mra, m_mwv, m_mwa, m_mwd}, 0);
            reset = 1'b0;
         end
      join
      check("reset_reclaim_latency", lat, 13);

      // parallel: two channels serve consumers 0 and 3 together
      p_cra[0] = 8'h20; p_cra[3] = 8'h33;
      p_crv[0] = 1'b1;  p_crv[3] = 1'b1;
      p_rq.push_back(mk(0, mem[8'h20]));
      p_rq.push_back(mk(3, mem[8'h33]));
      @(posedge clk); #1;
      check("par_valid_not_early", p_mrv, 2'b00);
      @(posedge clk); #1;
      check("par_valid", p_mrv, 2'b11);
      check("par_addr_ch0", p_mra[0], 8'h20);
      check("par_addr_ch1", p_mra[1], 8'h33);
      cnt = 2;
      do begin @(posedge clk); #1; cnt++; end while (!(p_crr[0] || p_crr[3]) && cnt < 40);
      check("par_latency", cnt, 4);
      check("par_ready0", p_crr[0], 1);
      check("par_ready3", p_crr[3], 1);
      p_crv = '0;
      @(posedge clk); #1;
      check("par_released", p_crr, 4'b0000);

      // read-only instance: write requests ignored, concurrent read completes
      p_cwa[1] = 8'h77; p_cwd[1] = 16'hBEEF; p_cwv[1] = 1'b1;
      p_cra[2] = 8'h05; p_crv[2] = 1'b1;
      p_rq.push_back(mk(2, mem[8'h05]));
      cnt = 0;
      do begin
         @(posedge clk); #1; cnt++;
         check("ro_write_outputs_zero", |{p_mwv, p_mwa, p_mwd, p_cwr}, 0);
      end while (!p_crr[2] && cnt < 40);
      check("ro_read_latency", cnt, 4);
      p_crv[2] = 1'b0;
      @(posedge clk); #1;
      check("ro_read_released", p_crr[2], 0);
      check("ro_write_ready_zero", p_cwr, 4'b0000);
      p_cwv = '0;

      repeat (3) @(posedge clk);
      #1;
      check("m_rq_drained", m_rq.size(), 0);
      check("m_wq_drained", m_wq.size(), 0);
      check("p_rq_drained", p_rq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_channel_controller.md
Name: mem_channel_controller

Overview:
- Multi-channel memory request arbiter.
- Connects NUM_CONSUMERS requesters (LSUs or instruction fetchers) to NUM_CHANNELS memory ports, each using valid/ready handshakes.
- Each channel independently claims one pending consumer request, forwards it to memory, waits for completion, then returns the result to the consumer.
- One instance serves data memory (read/write); one serves instruction memory (read-only, WRITE_ENABLE=0).

Parameters:
- DATA_WIDTH, 16: width of read/write data words.
- ADDRESS_WIDTH, 8: width of memory addresses.
- NUM_CONSUMERS, 4: number of requesting clients.
- NUM_CHANNELS, 1: number of concurrent memory ports.
- WRITE_ENABLE, 1: 1 = read and write paths; 0 = read-only, write logic removed.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- consumer_read_valid, input, NUM_CONSUMERS: per-consumer read request.
- consumer_read_address, input, ADDRESS_WIDTH x NUM_CONSUMERS: read address per consumer.
- consumer_read_ready, output, NUM_CONSUMERS: read data valid / request complete.
- consumer_read_data, output, DATA_WIDTH x NUM_CONSUMERS: returned read data.
- consumer_write_valid, input, NUM_CONSUMERS: per-consumer write request.
- consumer_write_address, input, ADDRESS_WIDTH x NUM_CONSUMERS: write address.
- consumer_write_data, input, DATA_WIDTH x NUM_CONSUMERS: write data.
- consumer_write_ready, output, NUM_CONSUMERS: write complete.
- mem_read_valid, output, NUM_CHANNELS: channel read request.
- mem_read_address, output, ADDRESS_WIDTH x NUM_CHANNELS: channel read address.
- mem_read_ready, input, NUM_CHANNELS: memory read done; data valid this cycle.
- mem_read_data, input, DATA_WIDTH x NUM_CHANNELS: memory read data.
- mem_write_valid, output, NUM_CHANNELS: channel write request.
- mem_write_address, output, ADDRESS_WIDTH x NUM_CHANNELS: channel write address.
- mem_write_data, output, DATA_WIDTH x NUM_CHANNELS: channel write data.
- mem_write_ready, input, NUM_CHANNELS: memory write done.

Behaviour:
- All outputs are registered.
- Reset (synchronous, priority over everything, including mid-transaction):
  - All outputs 0; all channels IDLE; all consumer claims cleared.
  - In-flight requests are dropped; consumers must re-present them.
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - Scan consumers 0..NUM_CONSUMERS-1 and claim the lowest-index consumer that is not claimed and has read_valid or write_valid.
  - If that consumer asserts both, read takes priority.
  - Channels are evaluated in index order within one cycle; a claim by channel i is visible to channel i+1 in the same cycle, so no two channels ever claim the same consumer.
  - Read claim: latch address; next cycle mem_read_valid=1 with mem_read_address set; go to READ_WAITING.
  - Write claim: latch address and data; drive mem_write_valid/address/data; go to WRITE_WAITING.
- READ_WAITING:
  - Hold mem_read_valid and address until mem_read_ready=1.
  - Then capture mem_read_data into consumer_read_data[c], set consumer_read_ready[c]=1, drop mem_read_valid, go to READ_RELAYING.
- WRITE_WAITING:
  - Hold until mem_write_ready=1.
  - Then drop mem_write_valid, set consumer_write_ready[c]=1, go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING:
  - Hold ready (and read data) until the consumer deasserts the corresponding valid.
  - Then clear ready, release the claim, return to IDLE.
  - The released consumer becomes claimable from the following cycle.
- Minimum latency:
  - Request seen at edge N; mem valid visible after edge N+1.
  - With mem ready asserted immediately, consumer ready is visible after edge N+2.
- Arbitration is fixed priority; consumers beyond NUM_CHANNELS wait until a channel frees.
- consumer_read_data holds its last value after ready drops.
- WRITE_ENABLE=0:
  - mem_write_valid/address/data tied 0; consumer_write_ready tied 0.
  - consumer_write_valid ignored; mem_write_ready ignored (may be tied 0).

Decomposition:
- Shared package: channel state enum (3-bit).
- Global width macros stay in the common header: DATA_WIDTH, INSTRUCTION_WIDTH, DATA/INSTRUCTION_MEMORY_ADDRESS_WIDTH, plus their typedefs (data_t, data_memory_address_t, instruction_t, instruction_memory_address_t).
- Single module, no sub-modules. Channel loop and claim vector live in one always block to give the same-cycle claim visibility.

Test Plan:
- Single read: consumer 1 reads addr 0x2A, memory returns 0x1234 with ready 2 cycles later -> mem_read_address=0x2A; consumer_read_data[1]=0x1234 with ready=1; ready clears one cycle after valid drops.
- Single write: consumer 0 writes 0x00BE to 0x10 -> mem_write_valid/addr/data = 1/0x10/0x00BE held until mem_write_ready; then consumer_write_ready[0]=1.
- Parallel: NUM_CHANNELS=2, consumers 0 and 3 read in the same cycle -> channel 0 serves consumer 0, channel 1 serves consumer 3, same latency, no duplicate claim.
- Contention: NUM_CHANNELS=1, 3 consumers request together -> served in order 0, 1, 2, each only after the previous one releases.
- Read-only: WRITE_ENABLE=0 with consumer_write_valid=1 -> all write outputs stay 0; a concurrent read completes normally.
- Reset mid-read (in READ_WAITING) -> next cycle all outputs 0; the channel reclaims the still-valid request from IDLE.
